branch_ctrl: RTL
================

Name: branch_ctrl

Overview:
- Branch prediction and resolution controller for the 5-stage RV32I pipeline.
- Each cycle it looks up the IF-stage PC in a direct-mapped BTB with 2-bit saturating counters and supplies a predicted next PC.
- In EX it compares the branch comparator's taken/not-taken result and target against the prediction carried down the pipe, then drives redirect and flush on a mispredict.
- At the EX clock edge it updates the BTB, the counters and the statistics counters.

Parameters:
- IDX_W, 4: BTB index width; entries = 2^IDX_W; index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pred_en  in  1  1 = dynamic prediction; 0 = static predict-not-taken (BTB still trains).
- if_pc  in  32  PC currently being fetched.
- pred_taken  out  1  prediction for if_pc (combinational).
- pred_target  out  32  predicted target; equals if_pc+4 when pred_taken=0.
- ex_valid  in  1  EX holds a real instruction (not a bubble).
- ex_stall  in  1  EX frozen this cycle.
- ex_br_type  in  3  comparator type; 000 = not a branch, 001..101 = conditional branch.
- ex_br  in  1  comparator result (1 = taken).
- ex_pc  in  32  PC of EX instruction.
- ex_target  in  32  computed branch target.
- ex_pred_taken  in  1  prediction carried from IF.
- ex_pred_target  in  32  predicted target carried from IF.
- redirect  out  1  mispredict; PC mux selects redirect_pc.
- redirect_pc  out  32  ex_br ? ex_target : ex_pc+4.
- flush_if_id  out  1  equals redirect.
- flush_id_ex  out  1  equals redirect.
- br_cnt  out  CNT_W  resolved branches.
- mispred_cnt  out  CNT_W  mispredicted branches.

Behaviour:
- Resolution: res = ex_valid & ~ex_stall & (ex_br_type != 000).
- Lookup (combinational, same cycle as if_pc):
  - hit = valid[idx] & (tag[idx] == if_pc tag).
  - pred_taken = pred_en & hit & ctr[idx][1].
  - pred_target = pred_taken ? tgt[idx] : if_pc+4.
- Mispredict (combinational, same cycle as EX): mis = res & ((ex_br != ex_pred_taken) | (ex_br & ex_pred_taken & (ex_target != ex_pred_target))).
  - redirect, flush_if_id and flush_id_ex all equal mis.
  - Zero extra latency: the next-cycle PC is redirect_pc.
- BTB update (at posedge when res=1):
  - Hit on ex_pc: ctr saturates up if ex_br, down otherwise (00..11). If ex_br, write tgt=ex_target.
  - Miss and ex_br=1: allocate or overwrite the entry; valid=1, tag, tgt=ex_target, ctr=10.
  - Miss and ex_br=0: no write.
  - ex_br_type 110/111 is treated as not a branch: no update, no count, no redirect.
- Statistics (at posedge):
  - br_cnt += res.
  - mispred_cnt += mis.
  - Both wrap modulo 2^CNT_W.
- Read-before-write: when the IF lookup and the EX update hit the same index in one cycle, IF sees the pre-update entry.
- Stall: ex_stall=1 blocks res, so there is no update, no count and no redirect. Redirect asserts once, on the unstalled cycle.
- Bubble: ex_valid=0 forces res=0.
- pred_en is sampled combinationally; toggling it affects only lookups from that cycle on.
- Reset (synchronous):
  - All valid=0, all ctr=01, all tgt=0, counters=0.
  - redirect=0 during the reset cycle, because outputs are gated by ~rst.
  - A branch in EX during reset is dropped: no update, no count.

Test Plan:
- Reset, then if_pc=0x0000_0040 -> pred_taken=0, pred_target=0x44; br_cnt=mispred_cnt=0.
- EX branch pc=0x40, br_type=001, ex_br=1, target=0x80, pred_taken=0 -> redirect=1, redirect_pc=0x80, flushes=1; after edge, BTB[0] allocated with ctr=10, mispred_cnt=1, br_cnt=1. Next cycle if_pc=0x40 -> pred_taken=1, pred_target=0x80.
- Same branch resolved taken 3 more times with correct prediction -> no redirect; ctr saturates at 11. Then resolved not-taken (pred_taken=1) -> redirect_pc=0x44, ctr=10; predict still taken.
- Taken prediction to 0x80 but ex_target=0x90 -> redirect=1, redirect_pc=0x90, tgt updated to 0x90.
- ex_stall=1 for 2 cycles with a mispredicting branch in EX -> redirect=0 while stalled, redirect=1 exactly once on the release cycle; br_cnt increments by 1.
- pred_en=0 with a trained taken entry -> pred_taken=0; a taken branch still redirects and trains. Also: same-cycle lookup/update at idx 0 -> IF sees the old ctr. Also: rst asserted with a mispredict in EX -> redirect=0 and the table is cleared.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// Pipeline-side bundle for the branch controller: IF lookup, EX resolution and statistics.
// The master drives fetch/execute information; the slave is the controller.
interface branch_ctrl_if #(
   parameter int CNT_W = 32
);
   logic              pred_en;
   logic [31:0]       if_pc;
   logic              pred_taken;
   logic [31:0]       pred_target;
   logic              ex_valid;
   logic              ex_stall;
   logic [2:0]        ex_br_type;
   logic              ex_br;
   logic [31:0]       ex_pc;
   logic [31:0]       ex_target;
   logic              ex_pred_taken;
   logic [31:0]       ex_pred_target;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              flush_if_id;
   logic              flush_id_ex;
   logic [CNT_W-1:0]  br_cnt;
   logic [CNT_W-1:0]  mispred_cnt;

   modport master (
      output pred_en, if_pc, ex_valid, ex_stall, ex_br_type, ex_br, ex_pc,
             ex_target, ex_pred_taken, ex_pred_target,
      input  pred_taken, pred_target, redirect, redirect_pc, flush_if_id,
             flush_id_ex, br_cnt, mispred_cnt
   );

   modport slave (
      input  pred_en, if_pc, ex_valid, ex_stall, ex_br_type, ex_br, ex_pc,
             ex_target, ex_pred_taken, ex_pred_target,
      output pred_taken, pred_target, redirect, redirect_pc, flush_if_id,
             flush_id_ex, br_cnt, mispred_cnt
   );
endinterface

// File: rtl/branch_ctrl.sv
// Direct-mapped BTB with 2-bit counters: predicts in IF, resolves and trains in EX.
// Lookups read the pre-update table, so same-index IF/EX cycles see the old entry.
module branch_ctrl #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 32
) (
   input logic           clk,
   input logic           rst,
   branch_ctrl_if.slave  bus
);
   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = 30 - IDX_W;

   logic              valid_q [ENTRIES];
   logic [TAG_W-1:0]  tag_q   [ENTRIES];
   logic [31:0]       tgt_q   [ENTRIES];
   logic [1:0]        ctr_q   [ENTRIES];
   logic [CNT_W-1:0]  br_cnt_q;
   logic [CNT_W-1:0]  mispred_cnt_q;

   logic [IDX_W-1:0]  if_idx;
   logic [TAG_W-1:0]  if_tag;
   logic              if_hit;
   logic [IDX_W-1:0]  ex_idx;
   logic [TAG_W-1:0]  ex_tag;
   logic              ex_hit;
   logic              is_branch;
   logic              res;
   logic              mis;
   logic              unused_pc_bits;

   assign unused_pc_bits = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

   assign if_idx = bus.if_pc[IDX_W+1:2];
   assign if_tag = bus.if_pc[31:IDX_W+2];
   assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

   assign bus.pred_taken  = ~rst & bus.pred_en & if_hit & ctr_q[if_idx][1];
   assign bus.pred_target = bus.pred_taken ? tgt_q[if_idx] : bus.if_pc + 32'd4;

   assign ex_idx = bus.ex_pc[IDX_W+1:2];
   assign ex_tag = bus.ex_pc[31:IDX_W+2];
   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   // Types 110/111 are reserved and behave exactly like "not a branch".
   assign is_branch = (bus.ex_br_type != 3'b000) && (bus.ex_br_type <= 3'b101);
   assign res = ~rst & bus.ex_valid & ~bus.ex_stall & is_branch;
   assign mis = res & ((bus.ex_br != bus.ex_pred_taken) |
                       (bus.ex_br & bus.ex_pred_taken & (bus.ex_target != bus.ex_pred_target)));

   assign bus.redirect    = mis;
   assign bus.flush_if_id = mis;
   assign bus.flush_id_ex = mis;
   assign bus.redirect_pc = bus.ex_br ? bus.ex_target : bus.ex_pc + 32'd4;
   assign bus.br_cnt      = br_cnt_q;
   assign bus.mispred_cnt = mispred_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= 2'b01;
         end
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (res) begin
            if (ex_hit) begin
               if (bus.ex_br) begin
                  if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                  tgt_q[ex_idx] <= bus.ex_target;
               end else if (ctr_q[ex_idx] != 2'b00) begin
                  ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
               end
            end else if (bus.ex_br) begin
               // A taken miss claims the slot, evicting any aliasing entry.
               valid_q[ex_idx] <= 1'b1;
               tag_q[ex_idx]   <= ex_tag;
               tgt_q[ex_idx]   <= bus.ex_target;
               ctr_q[ex_idx]   <= 2'b10;
            end
         end
         br_cnt_q      <= br_cnt_q + CNT_W'(res);
         mispred_cnt_q <= mispred_cnt_q + CNT_W'(mis);
      end
   end
endmodule
